// File: rtl/gsim_solver_param.sv
// Gauss-Seidel / Jacobi solver for an N x N system A.x = b, one serial MAC per cycle.
// Latency: o_done after edge k+1+I*N*(N+3) from the start edge k (I = iterations completed).
// Backpressure: none; i_module_en held for the run, results held in S_HOLD until it drops.
module gsim_solver_param #(
    parameter int N  = 16,
    parameter int IW = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_module_en,
    input  logic [N*N*16-1:0] i_a,
    input  logic [N*16-1:0]   i_b,
    input  logic [IW-1:0]     i_iter,
    input  logic [31:0]       i_tol,
    input  logic              i_mode,
    output logic [N*32-1:0]   o_x,
    output logic              o_done,
    output logic              o_busy,
    output logic [IW-1:0]     o_iter_used,
    output logic              o_converged
);
    localparam int RW = $clog2(N + 3);
    localparam int CW = $clog2(N);
    localparam int AW = $clog2(N * N);

    typedef enum logic [1:0] {S_WAIT, S_LOAD, S_EX, S_HOLD} state_t;

    // Clamp wider signed values into S15.16 range without wrapping.
    function automatic logic signed [31:0] sat_from48(input logic signed [47:0] v);
        if (v[47:31] == {17{v[47]}}) return v[31:0];
        return v[47] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    endfunction

    function automatic logic signed [31:0] sat_from37(input logic signed [36:0] v);
        if (v[36:31] == {6{v[36]}}) return v[31:0];
        return v[36] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    endfunction

    function automatic logic signed [31:0] sat_from34(input logic signed [33:0] v);
        if (v[33:31] == {3{v[33]}}) return v[31:0];
        return v[33] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    endfunction

    function automatic logic signed [31:0] mul16(input logic signed [15:0] a, input logic signed [15:0] b);
        return 32'(a) * 32'(b);
    endfunction

    state_t             state_q;
    logic signed [15:0] a_q  [N*N];
    logic signed [15:0] b_q  [N];
    logic signed [31:0] x_q  [N];
    logic signed [31:0] xp_q [N];
    logic [IW-1:0]      iter_q;
    logic [31:0]        tol_q;
    logic               mode_q;
    logic [RW-1:0]      round_q;
    logic [CW-1:0]      row_q;
    logic signed [36:0] sum_q;
    logic signed [47:0] ax_q;
    logic signed [47:0] p_q;
    logic [31:0]        maxd_q;

    logic [CW-1:0]      col;
    logic [AW-1:0]      a_idx;
    logic [AW-1:0]      d_idx;
    logic signed [15:0] a_col;
    logic signed [15:0] diag;
    logic signed [31:0] xsrc;
    logic signed [31:0] x_new;
    logic signed [31:0] x_old;
    logic [32:0]        diff;
    logic [32:0]        mag;
    logic [31:0]        delta;
    logic [31:0]        maxd_next;
    logic               col_is_diag;
    logic               row_last;
    logic               unused_p;

    // Only the S15.16 window of the product feeds x; low fraction bits are dropped.
    assign unused_p = ^p_q[13:0];

    // Result bus is the live X bank.
    always_comb begin
        for (int i = 0; i < N; i++) o_x[i*32 +: 32] = x_q[i];
    end

    // Operand selection, new x value and delta for the current row/round.
    always_comb begin
        col         = (round_q < RW'(N)) ? CW'(round_q) : '0;
        a_idx       = AW'(int'(col) * N + int'(row_q));
        d_idx       = AW'(int'(row_q) * N + int'(row_q));
        a_col       = a_q[a_idx];
        diag        = a_q[d_idx];
        // Jacobi reads the snapshot, except at its first read where the snapshot is being taken.
        xsrc        = (mode_q && !(row_q == '0 && round_q == '0)) ? xp_q[col] : x_q[col];
        x_new       = sat_from34(p_q[47:14]);
        x_old       = x_q[row_q];
        diff        = {x_new[31], x_new} - {x_old[31], x_old};
        mag         = diff[32] ? (~diff + 33'd1) : diff;
        delta       = mag[32] ? 32'hFFFF_FFFF : mag[31:0];
        maxd_next   = (delta > maxd_q) ? delta : maxd_q;
        col_is_diag = ((int'(round_q) - 1) == int'(row_q));
        row_last    = (row_q == CW'(N - 1));
    end

    // Control FSM plus the serial MAC datapath.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= S_WAIT;
            for (int k = 0; k < N*N; k++) a_q[k] <= '0;
            for (int i = 0; i < N; i++) begin
                b_q[i]  <= '0;
                x_q[i]  <= '0;
                xp_q[i] <= '0;
            end
            iter_q      <= '0;
            tol_q       <= '0;
            mode_q      <= 1'b0;
            round_q     <= '0;
            row_q       <= '0;
            sum_q       <= '0;
            ax_q        <= '0;
            p_q         <= '0;
            maxd_q      <= '0;
            o_done      <= 1'b0;
            o_busy      <= 1'b0;
            o_iter_used <= '0;
            o_converged <= 1'b0;
        end else begin
            case (state_q)
                S_WAIT: begin
                    if (i_module_en) begin
                        for (int k = 0; k < N*N; k++) a_q[k] <= i_a[k*16 +: 16];
                        for (int i = 0; i < N; i++) begin
                            b_q[i] <= i_b[i*16 +: 16];
                            // Raw X0 in S17.14; rescaled to S15.16 in S_LOAD.
                            x_q[i] <= mul16(i_b[i*16 +: 16], i_a[(i*N+i)*16 +: 16]);
                        end
                        iter_q      <= i_iter;
                        tol_q       <= i_tol;
                        mode_q      <= i_mode;
                        o_iter_used <= '0;
                        o_converged <= 1'b0;
                        o_busy      <= 1'b1;
                        state_q     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    for (int i = 0; i < N; i++) x_q[i] <= sat_from34({x_q[i], 2'b00});
                    if (iter_q == '0) begin
                        o_done  <= 1'b1;
                        o_busy  <= 1'b0;
                        state_q <= S_HOLD;
                    end else begin
                        row_q   <= '0;
                        round_q <= '0;
                        maxd_q  <= '0;
                        state_q <= S_EX;
                    end
                end
                S_EX: begin
                    if (round_q < RW'(N)) ax_q <= 48'(a_col) * 48'(xsrc);
                    if (round_q == '0) begin
                        sum_q <= {{5{b_q[row_q][15]}}, b_q[row_q], 16'h0000};
                        if (row_q == '0) begin
                            for (int i = 0; i < N; i++) xp_q[i] <= x_q[i];
                        end
                    end else if (round_q <= RW'(N) && !col_is_diag) begin
                        sum_q <= sum_q - 37'(sat_from48(ax_q));
                    end
                    if (round_q == RW'(N + 1)) p_q <= 48'(diag) * 48'(sat_from37(sum_q));
                    if (round_q == RW'(N + 2)) begin
                        x_q[row_q] <= x_new;
                        round_q    <= '0;
                        maxd_q     <= maxd_next;
                        if (row_last) begin
                            o_iter_used <= o_iter_used + IW'(1);
                            if (tol_q != '0 && maxd_next < tol_q) begin
                                o_converged <= 1'b1;
                                o_done      <= 1'b1;
                                o_busy      <= 1'b0;
                                state_q     <= S_HOLD;
                            end else if ((o_iter_used + IW'(1)) == iter_q) begin
                                o_done  <= 1'b1;
                                o_busy  <= 1'b0;
                                state_q <= S_HOLD;
                            end else begin
                                maxd_q <= '0;
                                row_q  <= '0;
                            end
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end else begin
                        round_q <= round_q + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!i_module_en) begin
                        o_done  <= 1'b0;
                        state_q <= S_WAIT;
                    end
                end
                default: state_q <= S_WAIT;
            endcase
        end
    end
endmodule

// File: doc/gsim_solver_param.md
# gsim_solver_param

Parametrised Gauss-Seidel / Jacobi linear-system solver: the next generation of the 16×16 fixed-iteration solver. It solves A·x = b for an N×N system with one serial MAC per cycle. The iteration count is set at run time, early exit on convergence is optional, and Jacobi or Gauss-Seidel update order is selectable. It sits behind the same enable/done handshake used by the existing solver and drives its result vector straight to the output bus.

## Interface
- N, 16, system dimension (2..32).
- IW, 8, width of iteration-count input/output.
- i_clk  in  1  clock, all state on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_module_en  in  1  start request; held high for the whole run, dropped to release results.
- i_a  in  N*N*16  coefficients.
  - 16-bit word k = j*N+i holds A[i][j].
  - Off-diagonal entries: signed integer S15.
  - Diagonal entry A[i][i]: reciprocal 1/a_ii, format S1.14.
- i_b  in  N*16  b[i] at bits [i*16 +:16], signed integer S15.
- i_iter  in  IW  number of iterations to run; 0 means X0 only.
- i_tol  in  32  convergence threshold, unsigned, format .16; 0 disables early exit.
- i_mode  in  1  0 = Gauss-Seidel (live x), 1 = Jacobi (previous-iteration x).
- o_x  out  N*32  x[i] at bits [i*32 +:32], S15.16.
- o_done  out  1  result valid; registered.
- o_busy  out  1  high in S_LOAD and S_EX.
- o_iter_used  out  IW  iterations actually completed.
- o_converged  out  1  run ended by the convergence test.

## Operation
- States and transitions:
  - S_WAIT: on i_module_en=1, latch A, b, i_iter, i_tol, i_mode; compute raw X0[i] = b[i]·A[i][i] (S17.14); clear o_iter_used and o_converged → S_LOAD.
  - S_LOAD: convert X0 to S15.16 (<<2) with saturation. If the latched i_iter = 0 → S_HOLD with o_done set; else → S_EX.
  - S_EX: for each row i = 0..N-1, run round counter 0..N+2:
    - round 0: SUM = b<<16 (37-bit S20.16).
    - rounds 0..N-1: AX = A[i][r]·xsrc[r] (48-bit).
    - rounds 1..N: SUM −= sat32(AX) for column r−1 ≠ i.
    - round N+1: P = A[i][i]·sat32(SUM) (48-bit S17.30).
    - round N+2: x[i] = sat of P[45:14]; fold |x_new − x_old| into the running iteration max-delta.
  - S_HOLD: o_done=1; outputs frozen. On i_module_en=0 → S_WAIT, with o_done low after that edge.
- xsrc selection:
  - Gauss-Seidel: live X bank.
  - Jacobi: X_prev bank, snapshotted from X at round 0 of row 0 of every iteration.
- End of iteration (row N-1, round N+2): increment o_iter_used.
  - If i_tol ≠ 0 and max-delta < i_tol: set o_converged, → S_HOLD, o_done set.
  - Else if o_iter_used+1 = latched i_iter: → S_HOLD, o_done set.
  - Else: clear max-delta and start the next iteration at row 0.
- Saturation: any value outside S15.16 clamps to 0x7FFFFFFF / 0x80000000. Deltas are computed 33-bit and absolute-valued; a delta ≥ 2^32 is treated as 0xFFFFFFFF.
- Inputs changing after the start edge are ignored. i_module_en falling during S_LOAD or S_EX is ignored; the run completes first.
- o_x always reflects the X bank; it holds after completion until the next start edge overwrites it with X0.

## Timing
- Reset values: o_x=0, o_done=0, o_busy=0, o_iter_used=0, o_converged=0, state S_WAIT; all internal banks are 0.
- Let edge k be the edge that samples i_module_en=1 in S_WAIT. Cycles per iteration = N·(N+3).
- o_done rises after edge k+1+I·N·(N+3), where I is the number of iterations completed; it stays high until the edge after i_module_en=0 is seen in S_HOLD.
- i_iter=0: o_done rises after edge k+1; o_x = saturated X0.
- x[i] updates on round N+2 of its row. In Gauss-Seidel mode the new x[i] is visible to row i+1 at its round i.
- Reset asserted mid-run: immediate return to reset values, no partial o_done. The first start after reset release behaves normally.
- i_module_en held high in S_WAIT after a HOLD→WAIT return starts a new run.

## Test plan
- N=4, A=identity (diag 0x4000, off-diag 0), b={1,2,−3,100}, i_iter=1, i_tol=0 → o_x={0x00010000, 0x00020000, 0xFFFD0000, 0x00640000}, o_done after edge k+29, o_iter_used=1, o_converged=0.
- N=4, diag entries A[0][0] and A[1][1] = 0x1000, A[0][1]=A[1][0]=1, rows 2–3 identity, b0=b1=4, b2=b3=0, i_iter=1:
  - i_mode=0 → x0=0x0000C000, x1=0x0000D000.
  - i_mode=1 → x0=x1=0x0000C000.
- Same system as the first case, i_iter=10, i_tol=1 → o_converged=1, o_iter_used=1, o_done after edge k+29.
- b0=0x7FFF, A[0][0]=0x7FFF, i_iter=0 → x0=0x7FFFFFFF, o_done after edge k+1.
- b0=0x8000, A[0][0]=0x7FFF → x0=0x80000000. Off-diagonal 0x7FFF with x=0x7FFFFFFF → AX clamps; SUM and x saturate with no wrap.
- Reset pulse at mid-run cycle 50 → all outputs 0 next cycle. Restart → correct result at nominal latency. Dropping i_module_en mid-run → run completes, then o_done falls one edge after the drop is seen in S_HOLD.
